// File: rtl/trigger_block_request.sv
// Trigger-to-readout request queue: turns T1 rising edges into block read
// requests (start/end block, trigger type, event number) and delivers them
// over a valid/ready interface. Events that arrive while the queue is full
// are dropped, pulsed on dropped_o and counted.
module trigger_block_request #(
    parameter int unsigned BLOCK_BITS = 9,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_L4     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [BLOCK_BITS-1:0] block_counter_i,
    input  logic                  T1_i,
    input  logic [BLOCK_BITS-1:0] T1_offset_i,
    input  logic [3:0]            T1_length_i,
    input  logic [NUM_L4-1:0]     l4_matched_i,
    output logic                  T1_mask_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [BLOCK_BITS-1:0] req_start_block_o,
    output logic [BLOCK_BITS-1:0] req_end_block_o,
    output logic [NUM_L4-1:0]     req_type_o,
    output logic [15:0]           req_event_o,
    output logic                  dropped_o,
    output logic [7:0]            drop_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MASK_C = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] TWO_C  = CNT_W'(2);

    typedef struct packed {
        logic [BLOCK_BITS-1:0] start_block;
        logic [BLOCK_BITS-1:0] end_block;
        logic [NUM_L4-1:0]     l4_type;
        logic [15:0]           event_num;
    } req_t;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t              state_q;
    req_t                head_q;
    req_t                mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                t1_prev_q;
    logic [15:0]         event_cnt_q;
    logic [7:0]          drop_cnt_q;
    logic                dropped_q;
    logic                mask_q;

    logic                t1_event_c;
    logic                push_c;
    logic                pop_c;
    logic [3:0]          len_c;
    logic [BLOCK_BITS-1:0] start_c;
    logic [BLOCK_BITS-1:0] end_c;
    req_t                new_req_c;
    logic [CNT_W-1:0]    count_next_c;
    logic [PTR_W-1:0]    rd_next_c;

    // Edge detect, admission against pre-pop occupancy, request payload.
    always_comb begin
        t1_event_c   = T1_i & ~t1_prev_q;
        push_c       = t1_event_c & (count_q < FULL_C);
        pop_c        = (state_q == ST_PRESENT) & req_ready_i;
        len_c        = (T1_length_i == 4'd0) ? 4'd1 : T1_length_i;
        start_c      = block_counter_i - T1_offset_i;
        end_c        = start_c + BLOCK_BITS'(len_c) - BLOCK_BITS'(1);
        new_req_c    = '{start_block: start_c, end_block: end_c,
                         l4_type: l4_matched_i, event_num: event_cnt_q};
        count_next_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_next_c    = rd_ptr_q + PTR_W'(1);
    end

    // Queue storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= new_req_c;
        end
    end

    // Counters, pointers, drop tracking and the output-stage FSM.
    // head_q mirrors mem_q[rd_ptr_q] so the request outputs come from flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            t1_prev_q   <= 1'b1;
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
            dropped_q   <= 1'b0;
            mask_q      <= 1'b0;
        end else begin
            t1_prev_q <= T1_i;
            count_q   <= count_next_c;
            mask_q    <= (count_next_c >= MASK_C);
            dropped_q <= t1_event_c & ~push_c;
            if (push_c) begin
                wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
                event_cnt_q <= event_cnt_q + 16'd1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_next_c;
            end
            if (t1_event_c && !push_c && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (push_c) begin
                        head_q  <= new_req_c;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (pop_c) begin
                        if (count_q >= TWO_C) begin
                            head_q <= mem_q[rd_next_c];
                        end else if (push_c) begin
                            head_q <= new_req_c;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign req_valid_o       = (state_q == ST_PRESENT);
    assign req_start_block_o = head_q.start_block;
    assign req_end_block_o   = head_q.end_block;
    assign req_type_o        = head_q.l4_type;
    assign req_event_o       = head_q.event_num;
    assign T1_mask_o         = mask_q;
    assign dropped_o         = dropped_q;
    assign drop_count_o      = drop_cnt_q;

endmodule

// File: tb/tb_trigger_block_request.sv
// Directed bench for trigger_block_request with hand-computed expectations.
module tb_trigger_block_request;

    logic       clk_i;
    logic       rst_n_i;
    logic [8:0] block_counter_i;
    logic       T1_i;
    logic [8:0] T1_offset_i;
    logic [3:0] T1_length_i;
    logic [3:0] l4_matched_i;
    logic       T1_mask_o;
    logic       req_valid_o;
    logic       req_ready_i;
    logic [8:0] req_start_block_o;
    logic [8:0] req_end_block_o;
    logic [3:0] req_type_o;
    logic [15:0] req_event_o;
    logic       dropped_o;
    logic [7:0] drop_count_o;

    int tests;
    int fails;

    trigger_block_request dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .block_counter_i   (block_counter_i),
        .T1_i              (T1_i),
        .T1_offset_i       (T1_offset_i),
        .T1_length_i       (T1_length_i),
        .l4_matched_i      (l4_matched_i),
        .T1_mask_o         (T1_mask_o),
        .req_valid_o       (req_valid_o),
        .req_ready_i       (req_ready_i),
        .req_start_block_o (req_start_block_o),
        .req_end_block_o   (req_end_block_o),
        .req_type_o        (req_type_o),
        .req_event_o       (req_event_o),
        .dropped_o         (dropped_o),
        .drop_count_o      (drop_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i     = 1'b0;
        T1_i        = 1'b0;
        req_ready_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    // Produce one isolated T1 edge (high one cycle, then low one cycle).
    task automatic pulse_t1(input logic [8:0] bc);
        block_counter_i = bc;
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int n;
        rst_n_i = 1'b0;
        T1_i = 1'b1;
        req_ready_i = 1'b0;
        block_counter_i = 9'd0; T1_offset_i = 9'd0; T1_length_i = 4'd1; l4_matched_i = 4'd0;
        tick();
        tick();
        tests++;
        if (req_valid_o !== 1'b0 || T1_mask_o !== 1'b0 || dropped_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: valid=%b mask=%b dropped=%b, expected 0 0 0", req_valid_o, T1_mask_o, dropped_o);
        end
        tests++;
        if (drop_count_o !== 8'd0 || req_start_block_o !== 9'd0 || req_end_block_o !== 9'd0 ||
            req_type_o !== 4'd0 || req_event_o !== 16'd0) begin
            fails++;
            $display("FAIL reset_data: cnt=%0d start=%0d end=%0d type=%h ev=%0d, expected all 0",
                     drop_count_o, req_start_block_o, req_end_block_o, req_type_o, req_event_o);
        end
        rst_n_i = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_valid_o) n++;
        end
        tests++;
        if (n !== 0) begin
            fails++;
            $display("FAIL high_at_release: valid cycles=%0d, expected 0", n);
        end
        T1_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        req_ready_i = 1'b1;
        block_counter_i = 9'd5; T1_offset_i = 9'd10; T1_length_i = 4'd4; l4_matched_i = 4'b0101;
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (req_valid_o !== 1'b1 || req_start_block_o !== 9'd507 || req_end_block_o !== 9'd510 ||
            req_type_o !== 4'b0101 || req_event_o !== 16'd0) begin
            fails++;
            $display("FAIL basic_req: valid=%b start=%0d end=%0d type=%b ev=%0d, expected 1 507 510 0101 0",
                     req_valid_o, req_start_block_o, req_end_block_o, req_type_o, req_event_o);
        end
        tick();
        tests++;
        if (req_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: valid=%b, expected 0", req_valid_o);
        end
    endtask

    task automatic test_held();
        int n;
        do_reset();
        req_ready_i = 1'b1;
        T1_offset_i = 9'd0; T1_length_i = 4'd1; block_counter_i = 9'd20;
        T1_i = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_valid_o) n++;
        end
        tests++;
        if (n !== 1) begin
            fails++;
            $display("FAIL held_single: requests=%0d, expected 1", n);
        end
        T1_i = 1'b0;
        tick();
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (req_valid_o !== 1'b1 || req_event_o !== 16'd1) begin
            fails++;
            $display("FAIL held_reedge: valid=%b ev=%0d, expected 1 1", req_valid_o, req_event_o);
        end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        T1_offset_i = 9'd0; T1_length_i = 4'd1; l4_matched_i = 4'd3;
        for (int i = 0; i < 4; i++) begin
            pulse_t1(9'(i * 8));
            tests++;
            if (T1_mask_o !== (i >= 2)) begin
                fails++;
                $display("FAIL full_mask_%0d: mask=%b, expected %b", i, T1_mask_o, (i >= 2));
            end
            tests++;
            if (req_valid_o !== 1'b1 || req_event_o !== 16'd0 || req_start_block_o !== 9'd0) begin
                fails++;
                $display("FAIL full_hold_%0d: valid=%b ev=%0d start=%0d, expected 1 0 0",
                         i, req_valid_o, req_event_o, req_start_block_o);
            end
        end
        block_counter_i = 9'd100;
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (dropped_o !== 1'b1 || drop_count_o !== 8'd1) begin
            fails++;
            $display("FAIL full_drop: dropped=%b cnt=%0d, expected 1 1", dropped_o, drop_count_o);
        end
        tick();
        tests++;
        if (dropped_o !== 1'b0) begin
            fails++;
            $display("FAIL full_drop_pulse: dropped=%b, expected 0", dropped_o);
        end
        req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (req_valid_o !== 1'b1 || req_event_o !== 16'(k) || req_start_block_o !== 9'(k * 8)) begin
                fails++;
                $display("FAIL full_order_%0d: valid=%b ev=%0d start=%0d, expected 1 %0d %0d",
                         k, req_valid_o, req_event_o, req_start_block_o, k, k * 8);
            end
            tick();
        end
        tests++;
        if (req_valid_o !== 1'b0 || T1_mask_o !== 1'b0) begin
            fails++;
            $display("FAIL full_empty: valid=%b mask=%b, expected 0 0", req_valid_o, T1_mask_o);
        end
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (req_valid_o !== 1'b1 || req_event_o !== 16'd4) begin
            fails++;
            $display("FAIL full_next_event: valid=%b ev=%0d, expected 1 4", req_valid_o, req_event_o);
        end
        tick();
    endtask

    task automatic test_full_pop();
        int n;
        do_reset();
        T1_offset_i = 9'd0; T1_length_i = 4'd1;
        for (int i = 0; i < 4; i++) pulse_t1(9'(i));
        req_ready_i = 1'b1;
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (dropped_o !== 1'b1 || drop_count_o !== 8'd1 || T1_mask_o !== 1'b1) begin
            fails++;
            $display("FAIL fullpop_drop: dropped=%b cnt=%0d mask=%b, expected 1 1 1", dropped_o, drop_count_o, T1_mask_o);
        end
        tests++;
        if (req_valid_o !== 1'b1 || req_event_o !== 16'd1) begin
            fails++;
            $display("FAIL fullpop_head: valid=%b ev=%0d, expected 1 1", req_valid_o, req_event_o);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_valid_o) n++;
            tick();
        end
        tests++;
        if (n !== 3) begin
            fails++;
            $display("FAIL fullpop_occ: remaining=%0d, expected 3", n);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_ready_i = 1'b1;
        block_counter_i = 9'd511; T1_offset_i = 9'd0; T1_length_i = 4'd0;
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (req_valid_o !== 1'b1 || req_start_block_o !== 9'd511 || req_end_block_o !== 9'd511) begin
            fails++;
            $display("FAIL len0: valid=%b start=%0d end=%0d, expected 1 511 511", req_valid_o, req_start_block_o, req_end_block_o);
        end
        tick();
        block_counter_i = 9'd510; T1_length_i = 4'd4;
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (req_start_block_o !== 9'd510 || req_end_block_o !== 9'd1 || req_event_o !== 16'd1) begin
            fails++;
            $display("FAIL end_wrap: start=%0d end=%0d ev=%0d, expected 510 1 1", req_start_block_o, req_end_block_o, req_event_o);
        end
        tick();
    endtask

    task automatic test_drop_saturate();
        do_reset();
        T1_offset_i = 9'd0; T1_length_i = 4'd1;
        for (int i = 0; i < 264; i++) pulse_t1(9'd7);
        tests++;
        if (drop_count_o !== 8'd255) begin
            fails++;
            $display("FAIL drop_sat: cnt=%0d, expected 255", drop_count_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        T1_offset_i = 9'd0; T1_length_i = 4'd1;
        pulse_t1(9'd1);
        pulse_t1(9'd2);
        #1;
        rst_n_i = 1'b0;
        #1;
        tests++;
        if (req_valid_o !== 1'b0 || T1_mask_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: valid=%b mask=%b, expected 0 0", req_valid_o, T1_mask_o);
        end
        tick();
        tick();
        rst_n_i = 1'b1;
        req_ready_i = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_valid_o) n++;
        end
        tests++;
        if (n !== 0) begin
            fails++;
            $display("FAIL midreset_flush: requests=%0d, expected 0", n);
        end
        T1_i = 1'b1;
        tick();
        T1_i = 1'b0;
        tests++;
        if (req_valid_o !== 1'b1 || req_event_o !== 16'd0) begin
            fails++;
            $display("FAIL midreset_event: valid=%b ev=%0d, expected 1 0", req_valid_o, req_event_o);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_held();
        test_full();
        test_full_pop();
        test_wrap();
        test_drop_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trigger_block_request.md
TRIGGER_BLOCK_REQUEST -- requirements
Module: trigger_block_request

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter BLOCK_BITS, default 9: width of block numbers.
REQ-003 Parameter DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-004 Parameter NUM_L4, default 4: trigger-type bits.
REQ-005 Port clk_i, input, 1: system clock.
REQ-006 Port rst_n_i, input, 1: asynchronous active-low reset.
REQ-007 Port block_counter_i, input, BLOCK_BITS: free-running digitizer block counter.
REQ-008 Port T1_i, input, 1: T1 level from trigger handling.
REQ-009 Port T1_offset_i, input, BLOCK_BITS: block offset accompanying T1.
REQ-010 Port T1_length_i, input, 4: blocks to read per event.
REQ-011 Port l4_matched_i, input, NUM_L4: L4 types that formed T1.
REQ-012 Port T1_mask_o, output, 1: upstream trigger mask (almost full).
REQ-013 Port req_valid_o, output, 1: request available.
REQ-014 Port req_ready_i, input, 1: consumer accepts request.
REQ-015 Port req_start_block_o, output, BLOCK_BITS: first block to read.
REQ-016 Port req_end_block_o, output, BLOCK_BITS: last block to read.
REQ-017 Port req_type_o, output, NUM_L4: captured l4_matched_i.
REQ-018 Port req_event_o, output, 16: event number.
REQ-019 Port dropped_o, output, 1: one-cycle pulse for each T1 lost to a full FIFO.
REQ-020 Port drop_count_o, output, 8: saturating count of dropped T1s.

Function
REQ-021 A T1 event SHALL be T1_i=1 in a cycle where the registered previous T1_i=0; a held-high T1_i produces exactly one event.
REQ-022 On an event in cycle N, start = (block_counter_i - T1_offset_i) mod 2^BLOCK_BITS, using cycle-N values.
REQ-023 On the same event, nblocks = T1_length_i, with 0 treated as 1.
REQ-024 On the same event, end = (start + nblocks - 1) mod 2^BLOCK_BITS.
REQ-025 type = l4_matched_i in cycle N.
REQ-026 The event number SHALL be the value of a 16-bit counter; the counter increments only on accepted events and wraps from 0xFFFF to 0.
REQ-027 An event SHALL be accepted and written at the end of cycle N iff FIFO occupancy < DEPTH, evaluated before any same-cycle pop.
REQ-028 At full occupancy, a same-cycle pop SHALL NOT admit the event.
REQ-029 A rejected event SHALL pulse dropped_o in cycle N+1.
REQ-030 A rejected event SHALL increment drop_count_o, saturating at 255.
REQ-031 A rejected event SHALL NOT advance the event counter.
REQ-032 The output stage SHALL be a 2-state FSM: EMPTY (req_valid_o=0) and PRESENT (req_valid_o=1).
REQ-033 FSM transition EMPTY->PRESENT: FIFO not empty.
REQ-034 FSM transition PRESENT->EMPTY: handshake (req_valid_o and req_ready_i) with no further entry.
REQ-035 FSM transition PRESENT->PRESENT: handshake with a further entry, next entry presented the following cycle.
REQ-036 Latency: an event written into an empty FIFO in cycle N SHALL give req_valid_o=1 in cycle N+1.
REQ-037 Back-to-back requests SHALL be deliverable one per cycle while req_ready_i=1.
REQ-038 While req_valid_o=1 and req_ready_i=0, all req_* outputs SHALL be held stable.
REQ-039 req_valid_o SHALL NOT drop without a handshake.
REQ-040 Requests SHALL leave in write order.
REQ-041 Simultaneous push and pop with occupancy below DEPTH leaves occupancy unchanged.
REQ-042 FIFO pointers wrap mod DEPTH.
REQ-043 T1_mask_o = 1 when occupancy >= DEPTH-1; it is driven from registered occupancy with no combinational path from inputs.

Reset
REQ-044 While rst_n_i=0, req_valid_o, T1_mask_o and dropped_o SHALL be 0.
REQ-045 While rst_n_i=0, drop_count_o, the event counter, the FIFO occupancy and pointers SHALL be 0; req_* data outputs SHALL be 0; the FSM SHALL be in EMPTY.
REQ-046 The previous-T1 register SHALL reset to 1, so a T1_i already high at reset release generates no event.
REQ-047 Reset assertion mid-transfer SHALL discard all queued requests immediately and asynchronously.
REQ-048 Operation SHALL resume on the first clock edge after release.

Verification
REQ-049 Scenario: block_counter_i=5, T1_offset_i=10, T1_length_i=4, l4_matched_i=0101, req_ready_i=1 -> one request next cycle: start=507, end=510, type=0101, event=0.
REQ-050 Scenario: T1_i held high 20 cycles -> exactly one request; then 0->1 again gives event=1.
REQ-051 Scenario: req_ready_i=0, 4 separated T1 edges -> T1_mask_o=1 after the 3rd write; the 5th edge -> dropped_o pulse, drop_count_o=1, event counter stays 4; then req_ready_i=1 -> events 0..3 in order on 4 consecutive cycles.
REQ-052 Scenario: FIFO full with a pop and a T1 edge in the same cycle -> the edge is dropped and occupancy becomes 3.
REQ-053 Scenario: T1_length_i=0 at block_counter_i=511, T1_offset_i=0 -> start=end=511.
REQ-054 Scenario: rst_n_i pulsed low with 2 requests queued and req_valid_o=1 -> req_valid_o=0 immediately; no request is emitted after release; the next event is numbered 0.
